// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor
//   Watches a RISC-V core's retirement and store-commit streams and produces a
//   test verdict: pass, fail (with the failing test number) or timeout. It
//   recognises two verdict sources:
//   - a nonzero store to the tohost mailbox;
//   - retirement of END_PC, which is judged by gp (x3).
//   It also counts the RUN cycles and the instructions retired.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   start     in   begin / restart monitoring (clears counters and testnum)
//   ret_valid in   an instruction retires this cycle
//   ret_pc    in   PC of the retiring instruction
//   gp        in   architectural x3 value
//   st_valid  in   a store commits this cycle
//   st_addr   in   committed store address
//   st_data   in   committed store data
//   busy      out  monitor is running
//   done      out  a verdict is held
//   pass      out  verdict is pass
//   fail      out  verdict is fail
//   timeout   out  verdict is timeout
//   testnum   out  failing test number (0 unless fail)
//   cycles    out  RUN cycles elapsed (saturating)
//   retired   out  instructions retired in RUN (saturating)
module riscv_test_monitor #(
    parameter int unsigned       XLEN           = 32,
    parameter logic [XLEN-1:0]   END_PC         = 'h44,
    parameter logic [XLEN-1:0]   TOHOST_ADDR    = 'h1000,
    parameter logic [XLEN-1:0]   PASS_GP        = 'h1,
    parameter int unsigned       TIMEOUT_CYCLES = 6000,
    parameter int unsigned       CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ret_valid,
    input  logic [XLEN-1:0]  ret_pc,
    input  logic [XLEN-1:0]  gp,
    input  logic             st_valid,
    input  logic [XLEN-1:0]  st_addr,
    input  logic [XLEN-1:0]  st_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [XLEN-1:0]  testnum,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {StIdle, StRun, StPass, StFail, StTmo} state_e;

    // Value of cycles on the last permitted RUN clock; only used when the
    // timeout is enabled.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [XLEN-1:0]  testnum_q, testnum_d;
    logic             busy_q, done_q, pass_q, fail_q, timeout_q;

    logic             tohost_hit, end_hit, tmo_hit;
    logic [CNT_W-1:0] cycles_inc, retired_inc;

    assign tohost_hit  = st_valid && (st_addr == TOHOST_ADDR) && (st_data != '0);
    assign end_hit     = ret_valid && (ret_pc == END_PC);
    assign tmo_hit     = (TIMEOUT_CYCLES != 0) && (cycles_q == TMO_LAST);
    assign cycles_inc  = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);
    assign retired_inc = (retired_q == '1) ? retired_q : retired_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        cycles_d  = cycles_q;
        retired_d = retired_q;
        testnum_d = testnum_q;
        // start wins over everything, including a hit in the same cycle.
        if (start) begin
            state_d   = StRun;
            cycles_d  = '0;
            retired_d = '0;
            testnum_d = '0;
        end else if (state_q == StRun) begin
            cycles_d = cycles_inc;
            if (ret_valid) begin
                retired_d = retired_inc;
            end
            if (tohost_hit) begin
                if (st_data == XLEN'(1)) begin
                    state_d = StPass;
                end else begin
                    state_d   = StFail;
                    testnum_d = st_data >> 1;
                end
            end else if (end_hit) begin
                if (gp == PASS_GP) begin
                    state_d = StPass;
                end else begin
                    state_d   = StFail;
                    testnum_d = gp;
                end
            end else if (tmo_hit) begin
                state_d = StTmo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cycles_q  <= '0;
            retired_q <= '0;
            testnum_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycles_q  <= cycles_d;
            retired_q <= retired_d;
            testnum_q <= testnum_d;
            // Status flags are registered from the next state so they line up
            // with the state register without any output decode logic.
            busy_q    <= (state_d == StRun);
            done_q    <= (state_d == StPass) || (state_d == StFail) || (state_d == StTmo);
            pass_q    <= (state_d == StPass);
            fail_q    <= (state_d == StFail);
            timeout_q <= (state_d == StTmo);
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign fail    = fail_q;
    assign timeout = timeout_q;
    assign testnum = testnum_q;
    assign cycles  = cycles_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
module tb_riscv_test_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        ret_valid = 1'b0;
    logic [31:0] ret_pc = '0;
    logic [31:0] gp = '0;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;

    logic        busy, done, pass, fail, timeout;
    logic [31:0] testnum, cycles, retired;
    logic        busy0, done0, pass0, fail0, timeout0;
    logic [31:0] testnum0, cycles0, retired0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    riscv_test_monitor #(.TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .rst(rst), .start(start), .ret_valid(ret_valid), .ret_pc(ret_pc),
        .gp(gp), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .testnum(testnum), .cycles(cycles), .retired(retired)
    );

    riscv_test_monitor #(.TIMEOUT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .ret_valid(ret_valid), .ret_pc(ret_pc),
        .gp(gp), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .busy(busy0), .done(done0), .pass(pass0), .fail(fail0), .timeout(timeout0),
        .testnum(testnum0), .cycles(cycles0), .retired(retired0)
    );

    typedef struct {
        string       name;
        int          pre;        // retiring (non-END) cycles before the hit cycle
        logic        ret_valid;
        logic [31:0] ret_pc;
        logic [31:0] gp;
        logic        st_valid;
        logic [31:0] st_addr;
        logic [31:0] st_data;
        logic        e_busy, e_pass, e_fail;
        logic [31:0] e_testnum, e_cycles, e_retired;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        start = 1'b0; ret_valid = 1'b0; ret_pc = '0; gp = '0;
        st_valid = 1'b0; st_addr = '0; st_data = '0;
    endtask

    task automatic do_start();
        @(negedge clk);
        idle_inputs();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_all(input string n, input logic e_busy, input logic e_pass,
                             input logic e_fail, input logic e_tmo, input logic [31:0] e_tn,
                             input logic [31:0] e_cyc, input logic [31:0] e_ret);
        check({n, ".busy"}, 32'(busy), 32'(e_busy));
        check({n, ".done"}, 32'(done), 32'(e_pass | e_fail | e_tmo));
        check({n, ".pass"}, 32'(pass), 32'(e_pass));
        check({n, ".fail"}, 32'(fail), 32'(e_fail));
        check({n, ".timeout"}, 32'(timeout), 32'(e_tmo));
        check({n, ".testnum"}, testnum, e_tn);
        check({n, ".cycles"}, cycles, e_cyc);
        check({n, ".retired"}, retired, e_ret);
    endtask

    initial begin
        //          name        pre rv  pc      gp       sv  addr      data   busy pass fail tn cyc ret
        vecs[0] = '{"end_pass",  10, 1, 32'h44, 32'h1,   0, 32'h0,    32'h0, 0, 1, 0, 0, 11, 11};
        vecs[1] = '{"end_fail",  0,  1, 32'h44, 32'h5,   0, 32'h0,    32'h0, 0, 0, 1, 5, 1,  1};
        vecs[2] = '{"th_fail",   2,  0, 32'h0,  32'h0,   1, 32'h1000, 32'hB, 0, 0, 1, 5, 3,  2};
        vecs[3] = '{"th_prio",   0,  1, 32'h44, 32'h7,   1, 32'h1000, 32'h1, 0, 1, 0, 0, 1,  1};
        vecs[4] = '{"nvalid",    3,  0, 32'h44, 32'h1,   0, 32'h0,    32'h0, 1, 0, 0, 0, 4,  3};
        vecs[5] = '{"th_zero",   1,  0, 32'h0,  32'h0,   1, 32'h1000, 32'h0, 1, 0, 0, 0, 2,  1};
        vecs[6] = '{"th_addr",   0,  0, 32'h0,  32'h0,   1, 32'h1004, 32'h1, 1, 0, 0, 0, 1,  0};
        vecs[7] = '{"th_tn1",    0,  0, 32'h0,  32'h0,   1, 32'h1000, 32'h2, 0, 0, 1, 1, 1,  0};
        vecs[8] = '{"th_over",   5,  1, 32'h44, 32'hDEAD,1, 32'h1000, 32'h7, 0, 0, 1, 3, 6,  6};
        vecs[9] = '{"other_pc",  0,  1, 32'h40, 32'h1,   0, 32'h0,    32'h0, 1, 0, 0, 0, 1,  1};

        // Reset state
        repeat (3) @(negedge clk);
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        check_all("idle", 0, 0, 0, 0, 0, 0, 0);

        // Table-driven runs; each starts (or restarts) the monitor.
        foreach (vecs[i]) begin
            do_start();
            for (int k = 0; k < vecs[i].pre; k++) begin
                ret_valid = 1'b1; ret_pc = 32'h10 + 32'(4 * k); gp = 32'h1;
                @(negedge clk);
            end
            ret_valid = vecs[i].ret_valid; ret_pc = vecs[i].ret_pc; gp = vecs[i].gp;
            st_valid = vecs[i].st_valid; st_addr = vecs[i].st_addr; st_data = vecs[i].st_data;
            @(negedge clk);
            idle_inputs();
            check_all(vecs[i].name, vecs[i].e_busy, vecs[i].e_pass, vecs[i].e_fail, 1'b0,
                      vecs[i].e_testnum, vecs[i].e_cycles, vecs[i].e_retired);
        end

        // Terminal state ignores inputs; then start from PASS restarts cleanly.
        do_start();
        ret_valid = 1'b1; ret_pc = 32'h44; gp = 32'h1;
        @(negedge clk);
        ret_valid = 1'b1; ret_pc = 32'h44; gp = 32'h9;
        st_valid = 1'b1; st_addr = 32'h1000; st_data = 32'h6;
        @(negedge clk);
        @(negedge clk);
        idle_inputs();
        check_all("hold_pass", 0, 1, 0, 0, 0, 1, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_all("restart_pass", 1, 0, 0, 0, 0, 0, 0);

        // Restart in RUN beats a same-cycle failing end hit.
        ret_valid = 1'b1; ret_pc = 32'h20; gp = 32'h1;
        @(negedge clk);
        start = 1'b1; ret_valid = 1'b1; ret_pc = 32'h44; gp = 32'h5;
        @(negedge clk);
        idle_inputs();
        check_all("restart_run", 1, 0, 0, 0, 0, 0, 0);

        // Timeout after exactly 20 RUN cycles; the disabled-timeout copy keeps going.
        do_start();
        repeat (19) @(negedge clk);
        check_all("tmo_m1", 1, 0, 0, 0, 0, 19, 0);
        @(negedge clk);
        check_all("tmo", 0, 0, 0, 1, 0, 20, 0);
        repeat (1000) @(negedge clk);
        check("tmo_hold.cycles", cycles, 32'd20);
        check("notmo.busy", 32'(busy0), 32'd1);
        check("notmo.done", 32'(done0), 32'd0);
        check("notmo.cycles", cycles0, 32'd1020);

        // Asynchronous reset mid-RUN clears everything immediately.
        do_start();
        ret_valid = 1'b1; ret_pc = 32'h10;
        repeat (4) @(negedge clk);
        idle_inputs();
        #2 rst = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
        check("async_rst.dut0_cycles", cycles0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all("post_rst_idle", 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/riscv_test_monitor.md
RISCV_TEST_MONITOR -- requirements
Module: riscv_test_monitor

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- XLEN, 32, datapath width.
- END_PC, 32'h44, PC whose retirement ends the test.
- TOHOST_ADDR, 32'h1000, store address treated as the tohost mailbox.
- PASS_GP, 1, x3 (gp) value meaning pass at END_PC.
- TIMEOUT_CYCLES, 6000, RUN-cycle limit; 0 disables the timeout.
- CNT_W, 32, counter width.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1, single clock, rising-edge.
- rst, in, 1, asynchronous, active-low reset.
- start, in, 1, pulse that begins or restarts monitoring.
- ret_valid, in, 1, an instruction retires this cycle.
- ret_pc, in, XLEN, PC of the retiring instruction.
- gp, in, XLEN, current architectural x3 value.
- st_valid, in, 1, a store commits this cycle.
- st_addr, in, XLEN, committed store address.
- st_data, in, XLEN, committed store data.
- busy, out, 1, monitor is in RUN.
- done, out, 1, a verdict is held.
- pass, out, 1, verdict is pass.
- fail, out, 1, verdict is fail.
- timeout, out, 1, verdict is timeout.
- testnum, out, XLEN, failing test number (0 unless fail).
- cycles, out, CNT_W, RUN cycles elapsed.
- retired, out, CNT_W, instructions retired in RUN.
REQ-003 All outputs SHALL be registered; no combinational input-to-output path.

Function
REQ-004 The FSM SHALL have the states IDLE, RUN, PASS, FAIL and TMO; busy=1 only in RUN, and done=1 only in PASS, FAIL or TMO.
REQ-005 IDLE -> RUN on start=1. In this transition cycles, retired and testnum SHALL be cleared to 0.
REQ-006 In RUN, a tohost hit is st_valid && st_addr==TOHOST_ADDR && st_data!=0.
- st_data==1 SHALL go to PASS.
- Any other nonzero st_data SHALL go to FAIL with testnum <= st_data>>1.
REQ-007 In RUN, an end hit is ret_valid && ret_pc==END_PC.
- gp==PASS_GP SHALL go to PASS.
- Otherwise the FSM SHALL go to FAIL with testnum <= gp.
REQ-008 In RUN, when TIMEOUT_CYCLES!=0 and cycles==TIMEOUT_CYCLES-1 with no hit, the FSM SHALL go to TMO.
REQ-009 Priority within one cycle SHALL be: tohost hit, then end hit, then timeout.
REQ-010 A store to TOHOST_ADDR with st_data==0 SHALL be ignored.
REQ-011 ret_valid=0 with ret_pc==END_PC SHALL be ignored, so speculative or fetch-only PC matches do not count.
REQ-012 Verdict outputs SHALL assert in the cycle after the hit edge, with latency 1.
REQ-013 pass, fail and timeout SHALL be mutually exclusive, one-hot when done=1.
REQ-014 cycles SHALL increment by 1 on every RUN clock, including the terminating cycle, and SHALL saturate at all-ones.
REQ-015 retired SHALL increment on each RUN cycle with ret_valid=1, including the terminating retirement, and SHALL saturate.
REQ-016 Counters SHALL hold their values outside RUN.
REQ-017 PASS, FAIL and TMO SHALL hold until start=1, which restarts into RUN with counters cleared (same actions as REQ-005).
REQ-018 start=1 while in RUN SHALL restart: counters and testnum cleared, FSM stays in RUN. Restart SHALL take priority over any hit in that same cycle.
REQ-019 Inputs SHALL be ignored in IDLE and in the terminal states, except start.

Reset
REQ-020 rst=0 SHALL asynchronously force state IDLE and every output to 0, including cycles, retired and testnum.
REQ-021 Reset asserted mid-RUN SHALL discard all progress; the monitor SHALL remain idle after release until start.
REQ-022 Release of rst SHALL be synchronous to clk; the first start is accepted on the first rising edge after release.

Verification
REQ-023 start, then 10 cycles of ret_valid, then ret_pc=0x44 with gp=1 -> next cycle pass=1, done=1, retired=11, cycles=11, testnum=0.
REQ-024 start, then ret_pc=0x44 with gp=5 -> fail=1 and testnum=5. A repeat run with st_valid to 0x1000 and st_data=0xB -> fail=1 and testnum=5.
REQ-025 Same cycle: tohost store of data 1 and an END_PC retire with gp=7 -> pass=1, because tohost wins.
REQ-026 TIMEOUT_CYCLES=20 with no hits -> timeout=1 after exactly 20 RUN cycles and cycles=20. The same run with TIMEOUT_CYCLES=0 -> no verdict after 1000 cycles.
REQ-027 Edge cases:
- ret_valid=0 with ret_pc=0x44 -> no verdict.
- tohost store of data 0 -> no verdict.
- rst=0 pulse mid-RUN -> all outputs 0 immediately, state IDLE.
- start in PASS -> busy=1, done=0, counters 0.
